candidate_filter_ctrl: RTL and testbench

//   Scan controller that sequences the shared hamming_distance unit over a candidate RAM.
//   On start it streams src_count words out of the source icblbc_ram, one read per cycle.
//   It compares each word against a latched reference word, and compacts every word with

---
 rtl/candidate_filter_ctrl.sv | 115 +++++++++++
 tb/tb_candidate_filter_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/candidate_filter_ctrl.sv
// Scan controller: streams src RAM words through the hamming unit and compacts survivors.
// Latency: word issued at cycle t is written to dst at t+2+HD_LAT; done at N+3+HD_LAT.
// Backpressure: none; one word per cycle, start is ignored while busy.
module candidate_filter_ctrl #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 8,
  parameter int HD_LAT = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [WIDTH-1:0]  ref_word,
  input  logic [3:0]        min_hd,
  input  logic [ADDR_W:0]   src_count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   out_count,
  output logic [ADDR_W-1:0] src_addr,
  input  logic [WIDTH-1:0]  src_q,
  output logic [WIDTH-1:0]  ham_a,
  output logic [WIDTH-1:0]  ham_b,
  input  logic [3:0]        ham_dist,
  output logic [ADDR_W-1:0] dst_addr,
  output logic [WIDTH-1:0]  dst_data,
  output logic              dst_wren
);

  // Valid slots: [0] = src_q valid, [HD_LAT] = ham_dist valid, [top] = survivor write.
  localparam int DEPTH = 2 + HD_LAT;
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DRAIN, ST_DONE} state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    ref_q;
  logic [3:0]          min_q;
  logic [ADDR_W:0]     cnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W:0]     out_cnt_q;
  logic [DEPTH-1:0]    vld_q;
  logic [WIDTH-1:0]    data_q [HD_LAT+1];
  logic                last_issue;

  assign last_issue = ({1'b0, addr_q} == (cnt_q - CNT_ONE));

  // Next-state logic for the scan sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = (src_count != '0) ? ST_SCAN : ST_DRAIN;
      ST_SCAN:  if (last_issue) state_d = ST_DRAIN;
      ST_DRAIN: if (vld_q[DEPTH-2:0] == '0) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State register, latched scan parameters and issue address.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      ref_q   <= '0;
      min_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && start) begin
        ref_q  <= ref_word;
        min_q  <= min_hd;
        cnt_q  <= src_count;
        addr_q <= '0;
      end else if (state_q == ST_SCAN && !last_issue) begin
        addr_q <= addr_q + ADDR_ONE;
      end
    end
  end

  // Valid/data pipeline; the top valid stage only keeps words that meet the threshold.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
      for (int k = 0; k <= HD_LAT; k++) data_q[k] <= '0;
    end else begin
      vld_q[0] <= (state_q == ST_SCAN);
      for (int k = 1; k < DEPTH-1; k++) vld_q[k] <= vld_q[k-1];
      vld_q[DEPTH-1] <= vld_q[DEPTH-2] && (ham_dist >= min_q);
      if (vld_q[0]) data_q[0] <= src_q;
      for (int k = 1; k <= HD_LAT; k++) data_q[k] <= data_q[k-1];
    end
  end

  // Survivor counter doubles as the compacted destination address.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_cnt_q <= '0;
    end else if (state_q == ST_IDLE && start) begin
      out_cnt_q <= '0;
    end else if (vld_q[DEPTH-1]) begin
      out_cnt_q <= out_cnt_q + CNT_ONE;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign out_count = out_cnt_q;
  assign src_addr  = addr_q;
  assign ham_a     = ref_q;
  assign ham_b     = src_q;
  assign dst_addr  = out_cnt_q[ADDR_W-1:0];
  assign dst_data  = data_q[HD_LAT];
  assign dst_wren  = vld_q[DEPTH-1];

endmodule

// File: tb/tb_candidate_filter_ctrl.sv
module tb_candidate_filter_ctrl;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] ref_word = '0;
  logic [3:0] min_hd = '0;
  logic [8:0] src_count = '0;
  logic       busy, done, dst_wren;
  logic [8:0] out_count;
  logic [7:0] src_addr, dst_addr;
  logic [7:0] src_q, ham_a, ham_b, dst_data;
  logic [3:0] ham_dist;

  logic [7:0] src_mem [256];
  logic [7:0] dst_mem [256];

  int total = 0;
  int bad = 0;
  int wren_seen = 0;

  candidate_filter_ctrl #(.WIDTH(8), .ADDR_W(8), .HD_LAT(1)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .ref_word(ref_word),
    .min_hd(min_hd), .src_count(src_count), .busy(busy), .done(done),
    .out_count(out_count), .src_addr(src_addr), .src_q(src_q), .ham_a(ham_a),
    .ham_b(ham_b), .ham_dist(ham_dist), .dst_addr(dst_addr), .dst_data(dst_data),
    .dst_wren(dst_wren)
  );

  always #5 clock = ~clock;

  // Source RAM (1-cycle read), registered hamming unit, destination RAM.
  always @(posedge clock) src_q <= src_mem[src_addr];
  always @(posedge clock) ham_dist <= 4'($countones(ham_a ^ ham_b));
  always @(posedge clock) if (dst_wren) dst_mem[dst_addr] <= dst_data;
  always @(negedge clock) if (dst_wren) wren_seen++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One scan from IDLE; the expected survivor list comes straight from the threshold rule.
  task automatic run(input string tag, input logic [7:0] r, input logic [3:0] m,
                     input logic [8:0] n, input bit poke);
    logic [7:0] exp_q [$];
    int cyc, nw, first, last, maxa;
    bit got;
    for (int i = 0; i < int'(n); i++)
      if ($countones(src_mem[i] ^ r) >= int'(m)) exp_q.push_back(src_mem[i]);
    for (int i = 0; i < 256; i++) dst_mem[i] = 8'hEE;
    @(negedge clock);
    ref_word = r; min_hd = m; src_count = n; start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    cyc = 1; nw = 0; first = -1; last = -1; maxa = 0; got = 0;
    while (cyc < 2000) begin
      if (dst_wren) begin
        nw++;
        if (first < 0) first = cyc;
        last = cyc;
      end
      if (busy && !done && int'(src_addr) > maxa) maxa = int'(src_addr);
      if (done) begin
        got = 1;
        break;
      end
      if (poke && cyc == 2) begin
        start = 1'b1; ref_word = ~r; min_hd = 4'd0; src_count = 9'd3;
      end
      if (poke && cyc == 3) start = 1'b0;
      @(negedge clock);
      cyc++;
    end
    chk({tag, "_done_seen"}, 32'(got), 32'd1);
    chk({tag, "_done_cycle"}, 32'(cyc), (n == 0) ? 32'd2 : 32'(int'(n) + 4));
    chk({tag, "_busy_at_done"}, 32'(busy), 32'd1);
    chk({tag, "_out_count"}, 32'(out_count), 32'(exp_q.size()));
    chk({tag, "_wren_count"}, 32'(nw), 32'(exp_q.size()));
    if (n != 0) chk({tag, "_max_src_addr"}, 32'(maxa), 32'(int'(n) - 1));
    if (m == 0 && nw > 0) chk({tag, "_wren_back_to_back"}, 32'(last - first + 1), 32'(nw));
    for (int i = 0; i < exp_q.size(); i++)
      chk({tag, "_dst_word"}, 32'(dst_mem[i]), 32'(exp_q[i]));
    if (exp_q.size() < 256)
      chk({tag, "_dst_untouched"}, 32'(dst_mem[exp_q.size()]), 32'hEE);
    @(negedge clock);
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    chk({tag, "_idle_done"}, 32'(done), 32'd0);
    chk({tag, "_held_count"}, 32'(out_count), 32'(exp_q.size()));
  endtask

  initial begin
    logic [7:0] r;
    logic [8:0] n;
    logic [3:0] m;
    int w0;

    for (int i = 0; i < 256; i++) src_mem[i] = 8'(i);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_out_count", 32'(out_count), 32'd0);
    chk("rst_src_addr", 32'(src_addr), 32'd0);
    chk("rst_dst_wren", 32'(dst_wren), 32'd0);
    chk("rst_ham_a", 32'(ham_a), 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    run("pop4", 8'h00, 4'd4, 9'd256, 0);
    chk("pop4_count_163", 32'(out_count), 32'd163);
    run("ff_hd8", 8'hFF, 4'd8, 9'd256, 0);
    chk("ff_hd8_word0", 32'(dst_mem[0]), 32'h00);

    src_mem[0] = 8'hA5; src_mem[1] = 8'h00; src_mem[2] = 8'h3C;
    src_mem[3] = 8'hFF; src_mem[4] = 8'h01;
    run("hd0_five", 8'h5A, 4'd0, 9'd5, 0);
    run("empty", 8'h12, 4'd2, 9'd0, 0);
    run("one_poke", 8'h0F, 4'd1, 9'd1, 1);
    run("hd_over_width", 8'h00, 4'd9, 9'd20, 0);

    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < 256; i++) src_mem[i] = 8'($urandom);
      r = 8'($urandom);
      m = 4'($urandom_range(0, 10));
      n = 9'($urandom_range(1, 40));
      run("rand", r, m, n, it[0]);
    end

    for (int i = 0; i < 256; i++) src_mem[i] = 8'(i);
    @(negedge clock);
    ref_word = 8'h00; min_hd = 4'd0; src_count = 9'd256; start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    reset_n = 1'b0;
    #1;
    w0 = wren_seen;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_out_count", 32'(out_count), 32'd0);
    chk("midrst_src_addr", 32'(src_addr), 32'd0);
    chk("midrst_dst_wren", 32'(dst_wren), 32'd0);
    chk("midrst_dst_data", 32'(dst_data), 32'd0);
    chk("midrst_ham_a", 32'(ham_a), 32'd0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (20) @(negedge clock);
    chk("midrst_no_wren", 32'(wren_seen - w0), 32'd0);
    chk("midrst_idle", 32'(busy), 32'd0);
    src_mem[0] = 8'h81; src_mem[1] = 8'h7E; src_mem[2] = 8'hFF;
    run("post_rst", 8'h00, 4'd7, 9'd3, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
